// File: rtl/gameport_if.sv
// CPU-side game port signals of the one-shot timer.
// The host drives the trigger and axis inputs; the timer returns flags, buttons and busy.
interface gameport_if #(
    parameter int NUM_AXES = 4,
    parameter int CNT_W    = 8,
    parameter int PRESC_W  = 8
);
    logic                      wr;
    logic [PRESC_W-1:0]        presc_limit;
    logic                      dig_mode;
    logic [NUM_AXES*CNT_W-1:0] axis_in;
    logic [2*NUM_AXES-1:0]     dig_dir;
    logic [3:0]                btn_in;
    logic [NUM_AXES-1:0]       axis_out;
    logic [3:0]                btn_out;
    logic                      busy;

    modport master (
        output wr, presc_limit, dig_mode, axis_in, dig_dir, btn_in,
        input  axis_out, btn_out, busy
    );

    modport slave (
        input  wr, presc_limit, dig_mode, axis_in, dig_dir, btn_in,
        output axis_out, btn_out, busy
    );
endinterface

// File: rtl/gameport_timer.sv
// PC game port one-shot emulation: a prescaled position counter is compared
// against per-axis thresholds latched on each CPU write to the port.
module gameport_timer #(
    parameter int NUM_AXES = 4,
    parameter int CNT_W    = 8,
    parameter int PRESC_W  = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    gameport_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0] CNT_MID  = {1'b1, {(CNT_W-1){1'b0}}};

    logic [CNT_W-1:0]   counter;
    logic [PRESC_W-1:0] presc;
    logic [CNT_W-1:0]   thr     [NUM_AXES];
    logic [CNT_W-1:0]   thr_new [NUM_AXES];
    logic [NUM_AXES-1:0] hit;
    logic               tick;

    assign tick = bus.busy && !bus.wr && (presc == bus.presc_limit);

    // NOTE: every variable in an always_comb gets a value before any branch may
    // override it; a path that leaves one unassigned infers a latch.
    always_comb begin
        for (int i = 0; i < NUM_AXES; i++) begin
            thr_new[i] = {~bus.axis_in[i*CNT_W + CNT_W - 1], bus.axis_in[i*CNT_W +: CNT_W-1]};
            if (bus.dig_mode) begin
                unique case (bus.dig_dir[2*i +: 2])
                    2'b01:   thr_new[i] = '0;        // neg only
                    2'b10:   thr_new[i] = CNT_LAST;  // pos only
                    default: thr_new[i] = CNT_MID;   // centred
                endcase
            end
            hit[i] = (counter == thr[i]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bus.axis_out <= '0;
            bus.btn_out  <= 4'hF;
            bus.busy     <= 1'b0;
            counter      <= CNT_MAX;
            presc        <= '0;
            // NOTE: the thresholds are a few flops, not a RAM, so they take reset
            // and hold a defined all-ones value before the first write.
            for (int i = 0; i < NUM_AXES; i++) thr[i] <= CNT_MAX;
        end else begin
            bus.btn_out <= ~bus.btn_in;
            if (bus.wr) begin
                for (int i = 0; i < NUM_AXES; i++) thr[i] <= thr_new[i];
                bus.axis_out <= '1;
                bus.busy     <= 1'b1;
                counter      <= '0;
                presc        <= '0;
            end else if (bus.busy) begin
                // The last count lasts a single cycle: timeout lands on the first
                // edge that samples all-ones-minus-one.
                if (counter == CNT_LAST) begin
                    counter      <= CNT_MAX;
                    bus.busy     <= 1'b0;
                    bus.axis_out <= '0;
                end else begin
                    bus.axis_out <= bus.axis_out & ~hit;
                    if (tick) begin
                        presc   <= '0;
                        counter <= counter + 1'b1;
                    end else begin
                        presc   <= presc + 1'b1;
                    end
                end
            end
        end
    end
endmodule
